// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_if
//  Description : Commit-stage bundle between the pipeline and trap_ctrl.
//                Carries the committing instruction's trap information, the
//                CSR access port and the pipeline control/redirect outputs.
//                modport slave  : trap controller side
//                modport master : pipeline side
//  Signals     : valid_i        instruction at commit is valid
//                scause_i[7:0]  decoder exception code (SCAUSE_NOP = none)
//                sret_i         committing instruction is sret
//                irq_i          level external interrupt request
//                pc_i[31:0]     PC of the committing instruction
//                csr_we_i / csr_addr_i[11:0] / csr_wdata_i[31:0]  CSR write
//                csr_rdata_o[31:0]  combinational CSR read at csr_addr_i
//                stall_o / flush_o  pipeline freeze / kill
//                redirect_o / redirect_pc_o[31:0]  one-cycle PC redirect
//  Revision    : 1.0  initial release
// ============================================================================
interface trap_ctrl_if;
  logic        valid_i;
  logic [7:0]  scause_i;
  logic        sret_i;
  logic        irq_i;
  logic [31:0] pc_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  modport slave (
    input  valid_i, scause_i, sret_i, irq_i, pc_i,
    input  csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, stall_o, flush_o, redirect_o, redirect_pc_o
  );

  modport master (
    output valid_i, scause_i, sret_i, irq_i, pc_i,
    output csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, stall_o, flush_o, redirect_o, redirect_pc_o
  );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Supervisor trap controller. Takes synchronous exceptions,
//                sret and external interrupts at commit, updates the
//                supervisor CSRs (sstatus/stvec/sepc/scause) and drives a
//                fixed two-cycle flush + redirect sequence.
//  Ports       : clk   - rising-edge clock
//                rstn  - asynchronous active-low reset
//                bus   - trap_ctrl_if.slave (commit info, CSR port,
//                        stall/flush/redirect outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module trap_ctrl #(
  parameter logic [7:0]  SCAUSE_NOP = 8'h00,
  parameter logic [31:0] STVEC_RST  = 32'h0000_0000,
  parameter logic [6:0]  IRQ_CODE   = 7'd9
) (
  input  wire logic     clk,
  input  wire logic     rstn,
  trap_ctrl_if.slave    bus
);

  localparam logic [11:0] c_ADDR_SSTATUS = 12'h100;
  localparam logic [11:0] c_ADDR_STVEC   = 12'h105;
  localparam logic [11:0] c_ADDR_SEPC    = 12'h141;
  localparam logic [11:0] c_ADDR_SCAUSE  = 12'h142;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sie;
  logic        r_spie;
  logic [31:0] r_stvec;
  logic [31:0] r_sepc;
  logic [7:0]  r_scause;
  logic [31:0] r_target;
  logic [31:0] r_redirect_pc;

  logic        w_idle;
  logic        w_ev_exc;
  logic        w_ev_sret;
  logic        w_ev_irq;
  logic        w_ev_trap;
  logic        w_ev_any;
  logic [7:0]  w_trap_cause;
  logic        w_stall;
  logic        w_flush;
  logic        w_redirect;
  logic [31:0] w_rdata;

  // --------------------------------------------------------------------------
  // Event decode: only sampled in IDLE; priority exception > sret > interrupt.
  // --------------------------------------------------------------------------
  assign w_idle    = (r_state == S_IDLE);
  assign w_ev_exc  = w_idle & bus.valid_i & (bus.scause_i != SCAUSE_NOP);
  assign w_ev_sret = w_idle & bus.valid_i & ~w_ev_exc & bus.sret_i;
  assign w_ev_irq  = w_idle & bus.valid_i & ~w_ev_exc & ~bus.sret_i &
                     bus.irq_i & r_sie;
  assign w_ev_trap = w_ev_exc | w_ev_irq;
  assign w_ev_any  = w_ev_trap | w_ev_sret;

  assign w_trap_cause = w_ev_exc ? bus.scause_i : {1'b1, IRQ_CODE};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_redirect  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ev_any) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_stall     = 1'b1;
        w_flush     = 1'b1;
        w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_flush     = 1'b1;
        w_redirect  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CSR file. The CSR write is applied first; the event update is written
  // afterwards in the same block so that it wins on a collision while writes
  // to untouched CSRs still go through.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sie    <= 1'b0;
      r_spie   <= 1'b0;
      r_stvec  <= STVEC_RST;
      r_sepc   <= 32'h0000_0000;
      r_scause <= 8'h00;
    end else begin
      if (bus.csr_we_i) begin
        case (bus.csr_addr_i)
          c_ADDR_SSTATUS: begin
            r_sie  <= bus.csr_wdata_i[1];
            r_spie <= bus.csr_wdata_i[5];
          end
          c_ADDR_STVEC:  r_stvec  <= {bus.csr_wdata_i[31:2], 2'b00};
          c_ADDR_SEPC:   r_sepc   <= {bus.csr_wdata_i[31:2], 2'b00};
          c_ADDR_SCAUSE: r_scause <= bus.csr_wdata_i[7:0];
          default: ;
        endcase
      end
      if (w_ev_trap) begin
        r_sepc   <= bus.pc_i;
        r_scause <= w_trap_cause;
        r_spie   <= r_sie;
        r_sie    <= 1'b0;
      end else if (w_ev_sret) begin
        r_sie    <= r_spie;
        r_spie   <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Redirect target is latched only when the event is taken, so CSR writes
  // during FLUSH cannot disturb it. The visible redirect PC is a separate
  // register loaded on entry to REDIRECT so it holds the previous target
  // while no redirect is being signalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_target      <= 32'h0000_0000;
      r_redirect_pc <= 32'h0000_0000;
    end else begin
      if (w_ev_trap) begin
        r_target <= r_stvec;
      end else if (w_ev_sret) begin
        r_target <= r_sepc;
      end
      if (r_state == S_FLUSH) begin
        r_redirect_pc <= r_target;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Combinational CSR read; unmapped addresses read as zero.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (bus.csr_addr_i)
      c_ADDR_SSTATUS: w_rdata = {26'd0, r_spie, 3'd0, r_sie, 1'b0};
      c_ADDR_STVEC:   w_rdata = r_stvec;
      c_ADDR_SEPC:    w_rdata = r_sepc;
      c_ADDR_SCAUSE:  w_rdata = {24'd0, r_scause};
      default:        w_rdata = 32'h0000_0000;
    endcase
  end

  assign bus.csr_rdata_o   = w_rdata;
  assign bus.stall_o       = w_stall;
  assign bus.flush_o       = w_flush;
  assign bus.redirect_o    = w_redirect;
  assign bus.redirect_pc_o = r_redirect_pc;

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter SCAUSE_NOP, 8'h00, decoder "no exception" code.
REQ-002 SHALL have parameter STVEC_RST, 32'h0000_0000, stvec reset value.
REQ-003 SHALL have parameter IRQ_CODE, 7'd9, interrupt cause code; bit7 of scause is set for interrupts.
REQ-004 SHALL have port clk, input, 1, single clock, rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid_i, input, 1, instruction at commit is valid.
REQ-007 SHALL have port scause_i, input, 8, exception code from decoder; SCAUSE_NOP means none.
REQ-008 SHALL have port sret_i, input, 1, committing instruction is sret.
REQ-009 SHALL have port irq_i, input, 1, level external interrupt request.
REQ-010 SHALL have port pc_i, input, 32, PC of the committing instruction.
REQ-011 SHALL have ports csr_we_i / csr_addr_i / csr_wdata_i, input, 1/12/32, CSR write port.
REQ-012 SHALL have port csr_rdata_o, output, 32, combinational read of the CSR at csr_addr_i; 0 for unmapped addresses.
REQ-013 SHALL have port stall_o, output, 1, freeze the PC and pipeline registers.
REQ-014 SHALL have port flush_o, output, 1, kill in-flight instructions.
REQ-015 SHALL have ports redirect_o / redirect_pc_o, output, 1/32, one-cycle PC redirect with its target.

Function
REQ-016 SHALL implement the CSR map: sstatus 0x100 (bit1 SIE, bit5 SPIE, others read 0), stvec 0x105, sepc 0x141, scause 0x142 (8 bits, zero-extended on read).
REQ-017 SHALL force stvec[1:0] and sepc[1:0] to 0 on every write.
REQ-018 SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-019 In IDLE, an event SHALL be taken when valid_i=1 and one of the following holds, in priority order:
- sync exception: scause_i != SCAUSE_NOP;
- sret: sret_i=1;
- interrupt: irq_i=1 and SIE=1.
REQ-020 On taking a sync exception or interrupt, the edge SHALL set:
- sepc<=pc_i;
- scause<=scause_i, or {1'b1,IRQ_CODE} for an interrupt;
- SPIE<=SIE, SIE<=0;
- target<=stvec.
REQ-021 On taking an sret, the edge SHALL set SIE<=SPIE, SPIE<=1, target<=sepc; sepc and scause SHALL NOT change.
REQ-022 On any taken event, the FSM SHALL go IDLE->FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle with stall_o=1 and flush_o=1, then go to REDIRECT.
REQ-024 REDIRECT SHALL last exactly one cycle with redirect_o=1, redirect_pc_o=target, flush_o=1 and stall_o=0, then go to IDLE.
REQ-025 Latency SHALL be fixed: event sampled at edge T; flush_o is high in cycles T+1..T+2; redirect_o is high in cycle T+2 only.
REQ-026 In IDLE with no event, stall_o, flush_o and redirect_o SHALL be 0.
REQ-027 redirect_pc_o SHALL hold its last target when redirect_o=0.
REQ-028 In FLUSH and REDIRECT, valid_i, scause_i, sret_i and irq_i SHALL be ignored; an interrupt still pending is re-evaluated in the first IDLE cycle.
REQ-029 A CSR write SHALL take effect at the next edge in any state.
REQ-030 When a CSR write and a taken event hit the same CSR in the same cycle, the event update SHALL win; writes to other CSRs SHALL proceed.
REQ-031 A CSR write to stvec or sepc while in FLUSH SHALL NOT alter the latched target.
REQ-032 When valid_i=0, no event SHALL be taken regardless of the other inputs.
REQ-033 Back-to-back events SHALL be handled: an event presented in the IDLE cycle right after REDIRECT SHALL be accepted normally.

Reset
REQ-034 On rstn=0, asynchronously: state=IDLE; sstatus=0, stvec=STVEC_RST, sepc=0, scause=0, target=0; stall_o, flush_o, redirect_o, redirect_pc_o all 0.
REQ-035 Reset asserted mid-sequence (FLUSH or REDIRECT) SHALL abort the sequence with no redirect pulse.
REQ-036 Operation SHALL resume on the first rising clk edge after rstn deasserts.

Verification
REQ-037 ecall: stvec=0x8000_0100, valid_i=1, scause_i=8'h08, pc_i=0x0000_0040 -> T+1 flush_o=1 and stall_o=1; T+2 redirect_o=1 with redirect_pc_o=0x8000_0100; sepc=0x40, scause=0x08, SIE=0.
REQ-038 sret: sepc=0x44, SPIE=1, valid_i=1, sret_i=1 -> T+2 redirect_pc_o=0x44; sstatus reads 0x22.
REQ-039 Priority: scause_i=8'h02, sret_i=1, irq_i=1, SIE=1 in the same cycle -> scause=0x02, redirect to stvec.
REQ-040 Interrupt masking: irq_i=1 with SIE=0 -> no event; write sstatus=0x2 -> next valid cycle takes the interrupt, scause=0x89, SIE=0, SPIE=1.
REQ-041 Collision: csr write of sepc=0x1234 in the same cycle as an ecall at pc_i=0x80 -> sepc=0x80.
REQ-042 Reset mid-sequence: rstn low during FLUSH -> all outputs 0 immediately; no redirect_o pulse after release; stvec reads STVEC_RST.
